// File: rtl/fpu_cmd_framer.sv
// Collects the 9-byte UART command frame (opcode, A LSB first, B LSB first) into one FPU command on a valid/ready handshake.
// Optional inter-byte abort: define FPU_FRAME_TIMEOUT_EN to build the timeout counter.
module fpu_cmd_framer #(
  parameter int TIMEOUT_CYCLES = 312500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_op,
  output logic [31:0] cmd_a,
  output logic [31:0] cmd_b,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPA  = 2'd1,
    OPB  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t     state_r;
  logic [1:0] idx_r;
  logic       xfer_s;
  logic       op_ok_s;
  logic       tmo_hit_s;

  assign xfer_s  = cmd_valid && cmd_ready;
  assign op_ok_s = (rx_data[7:2] == 6'd0);

`ifdef FPU_FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_r;

  assign tmo_hit_s = busy && !rx_valid && (tmo_r == TW'(TIMEOUT_CYCLES - 1));

  // Idle-gap counter: runs only while a frame is partially received, cleared by any byte
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_r <= '0;
    end else if (busy && !rx_valid && !tmo_hit_s) begin
      tmo_r <= tmo_r + TW'(1);
    end else begin
      tmo_r <= '0;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Frame state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      cmd_valid <= 1'b0;
      cmd_op    <= 2'd0;
      cmd_a     <= 32'd0;
      cmd_b     <= 32'd0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_valid) begin
            if (op_ok_s) begin
              cmd_op  <= rx_data[1:0];
              idx_r   <= 2'd0;
              busy    <= 1'b1;
              state_r <= OPA;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        OPA: begin
          if (rx_valid) begin
            cmd_a[{idx_r, 3'b000} +: 8] <= rx_data;
            idx_r <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              state_r <= OPB;
            end
          end else if (tmo_hit_s) begin
            busy      <= 1'b0;
            frame_err <= 1'b1;
            state_r   <= IDLE;
          end
        end
        OPB: begin
          if (rx_valid) begin
            cmd_b[{idx_r, 3'b000} +: 8] <= rx_data;
            idx_r <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              busy      <= 1'b0;
              cmd_valid <= 1'b1;
              state_r   <= HOLD;
            end
          end else if (tmo_hit_s) begin
            busy      <= 1'b0;
            frame_err <= 1'b1;
            state_r   <= IDLE;
          end
        end
        HOLD: begin
          // A byte arriving in the transfer cycle is handled as if already back in IDLE
          if (xfer_s) begin
            cmd_valid <= 1'b0;
            state_r   <= IDLE;
            if (rx_valid) begin
              if (op_ok_s) begin
                cmd_op  <= rx_data[1:0];
                idx_r   <= 2'd0;
                busy    <= 1'b1;
                state_r <= OPA;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else if (rx_valid) begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          idx_r     <= 2'd0;
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fpu_cmd_framer.md
# fpu_cmd_framer

Assembles the 9-byte UART command frame (opcode byte, operand A LSB first, operand B LSB first) into a single parallel FPU command. Sits between the UART receiver and the FPU operation core inside `FPU23Bit`. Presents the command on a valid/ready handshake and holds it until the core accepts it. Discards malformed or stalled frames so the byte stream always resynchronises on an opcode byte.

## Interface
- `TIMEOUT_CYCLES`, default 312500: maximum idle clocks between bytes inside a frame, about 3 byte times at 9600 baud / 100 MHz.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte, valid only while `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `cmd_ready` in 1: FPU core accepts the command.
- `cmd_valid` out 1: command held and stable.
- `cmd_op` out 2: opcode. 00 add, 01 mul, 10 div, 11 sub.
- `cmd_a` out 32: operand A, IEEE-754 single.
- `cmd_b` out 32: operand B, IEEE-754 single.
- `busy` out 1: a frame is partially received (states OPA or OPB).
- `frame_err` out 1: one-cycle pulse when a byte or partial frame is discarded.

## Operation
- States:
  - IDLE: waiting for the opcode byte.
  - OPA: collecting A, 4 bytes.
  - OPB: collecting B, 4 bytes.
  - HOLD: `cmd_valid`=1.
- 2-bit byte index `idx` counts bytes within OPA and OPB. It resets to 0 on entry to each of those states.
- IDLE + `rx_valid`:
  - `rx_data[7:2]`=0: latch `cmd_op`=`rx_data[1:0]`, go to OPA.
  - Otherwise: drop the byte, pulse `frame_err`, stay in IDLE.
- OPA + `rx_valid`: `cmd_a[8*idx+7 : 8*idx]` = `rx_data`. When `idx`=3, go to OPB.
- OPB + `rx_valid`: same rule into `cmd_b`. When `idx`=3, go to HOLD.
- HOLD:
  - `cmd_valid`=1. `cmd_op`, `cmd_a` and `cmd_b` are stable until the transfer.
  - Transfer is `cmd_valid && cmd_ready`. The next state is IDLE.
  - `rx_valid` in HOLD without a transfer: drop the byte (overrun) and pulse `frame_err`.
  - `rx_valid` in the transfer cycle: treat it as an IDLE-state byte. A legal opcode moves to OPA.
- `cmd_a` and `cmd_b` are not cleared between frames. Their values are meaningful only while `cmd_valid`=1.
- Inter-byte timeout (only when `FPU_FRAME_TIMEOUT_EN` is defined):
  - Counter clears on every accepted byte and on entry to OPA.
  - Counter increments each cycle in OPA and OPB.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no `rx_valid`: go to IDLE and pulse `frame_err`.
  - If `rx_valid` arrives in that same cycle, the byte wins and the counter clears.

## Timing
- Reset values: state IDLE, `cmd_valid`=0, `busy`=0, `frame_err`=0, `cmd_op`=0, `cmd_a`=0, `cmd_b`=0, `idx`=0, timeout counter 0.
- Reset asserted mid-frame or in HOLD: everything returns to reset values on the next edge. The partial frame is lost and no `frame_err` pulse is generated.
- All outputs are registered.
- `cmd_valid` rises on the clock edge after the cycle carrying the 9th `rx_valid`, i.e. 1-cycle latency.
- With `cmd_ready` held high, `cmd_valid` is high for exactly 1 cycle.
- `cmd_valid` falls on the edge after the transfer cycle.
- `frame_err` is high for exactly one cycle per discard event.
- `busy` is 1 exactly in OPA and OPB.
- Minimum spacing of `rx_valid` is 1 cycle. Back-to-back strobes must all be accepted.

## Configuration
- `FPU_FRAME_TIMEOUT_EN` defined: the timeout counter (width `$clog2(TIMEOUT_CYCLES)`) and the abort path are built.
- Not defined: no counter. A stalled frame waits indefinitely, and only `reset` or further bytes advance it. `frame_err` is then caused only by an illegal opcode or an overrun.

## Test plan
- Basic add frame:
  - Stimulus: bytes 00, 00 00 60 40, 00 00 00 40 with `cmd_ready`=1.
  - Required: one-cycle `cmd_valid`, `cmd_op`=0, `cmd_a`=40600000, `cmd_b`=40000000.
- Backpressure:
  - Stimulus: frame 02, 00 00 C0 40, 00 00 00 40 with `cmd_ready`=0 for 20 cycles, then 1.
  - Required: `cmd_valid` held for 21 cycles, outputs stable at op 2 / 40C00000 / 40000000, then 0.
- Illegal opcode:
  - Stimulus: byte 0x55, then a valid frame 01, 00 00 00 40, 00 00 C0 3F.
  - Required: one `frame_err` pulse, then a command with `cmd_op`=1, `cmd_a`=40000000, `cmd_b`=3FC00000.
- Overrun and transfer-cycle byte:
  - Stimulus: with `cmd_ready`=0 in HOLD, send 0x03. Then raise `cmd_ready` in the same cycle as an `rx_valid` carrying 0x03.
  - Required: the first byte is dropped with `frame_err`. The second byte starts a new frame (`busy`=1, `cmd_op`=3).
- Timeout (`FPU_FRAME_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):
  - Stimulus: send 00, 11 22, then idle 16 cycles.
  - Required: `busy` falls, one `frame_err` pulse. A following full frame decodes correctly.
- Reset mid-frame:
  - Stimulus: send 00 and 3 bytes of A, pulse `reset`, then send a full 9-byte frame.
  - Required: the new frame decodes exactly, with no `frame_err` pulse.
